store_merge_rmw: RTL and testbench

- Store-side counterpart of the load path's sub-word sign/zero extension: narrows a 32-bit register value to a byte, halfword or word and writes it into word-organised data memory.
- Sub-word stores run a read-modify-write sequence: read the word, merge the narrowed lane, write the word back.
- Sits between the CPU store datapath and the 32-bit data memory port. Memory reads have one cycle of latency.

---
 rtl/store_merge_rmw.sv | 140 ++++++++++++++
 tb/tb_store_merge_rmw.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/store_merge_rmw.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | store_merge_rmw : narrows a store to byte/half/word and merges sub-words  |
// | into 32-bit memory via read-modify-write.          Revision: 1.0         |
// +--------------------------------------------------------------------------+
module store_merge_rmw #(
  parameter int ADDR_W     = 32,
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_data,
  input  logic [1:0]        req_size,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [31:0]       mem_rdata,
  output logic              mem_wr_en,
  output logic [31:0]       mem_wdata,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_WAIT  = 3'd2,
    S_WRITE = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  state_t      state;
  logic [15:0] data_q;
  logic [1:0]  lane_q;
  logic        half_q;

  logic        illegal;
  logic [1:0]  byte_lane;
  logic        half_lane;
  logic [31:0] merged;

  assign illegal = (req_size == 2'b11) ||
                   (req_size == 2'b01 && req_addr[0]) ||
                   (req_size == 2'b10 && req_addr[1:0] != 2'b00);

  // Big-endian mirrors the lane index; byte order inside a half is unchanged.
  assign byte_lane = BIG_ENDIAN ? ~lane_q    : lane_q;
  assign half_lane = BIG_ENDIAN ? ~lane_q[1] : lane_q[1];

  always_comb begin
    merged = mem_rdata;
    if (half_q) begin
      if (half_lane) merged[31:16] = data_q;
      else           merged[15:0]  = data_q;
    end else begin
      case (byte_lane)
        2'd0:    merged[7:0]   = data_q[7:0];
        2'd1:    merged[15:8]  = data_q[7:0];
        2'd2:    merged[23:16] = data_q[7:0];
        default: merged[31:24] = data_q[7:0];
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      req_ready <= 1'b1;
      mem_rd_en <= 1'b0;
      mem_wr_en <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      data_q    <= '0;
      lane_q    <= '0;
      half_q    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            data_q    <= req_data[15:0];
            lane_q    <= req_addr[1:0];
            half_q    <= req_size[0];
            if (illegal) begin
              state <= S_ERR;
              err   <= 1'b1;
            end else begin
              mem_addr <= {req_addr[ADDR_W-1:2], 2'b00};
              if (req_size == 2'b10) begin
                state     <= S_WRITE;
                mem_wr_en <= 1'b1;
                mem_wdata <= req_data;
                done      <= 1'b1;
              end else begin
                state     <= S_READ;
                mem_rd_en <= 1'b1;
              end
            end
          end
        end
        S_READ: begin
          mem_rd_en <= 1'b0;
          state     <= S_WAIT;
        end
        // Read data is valid during WAIT, so the merge is registered straight into the write word.
        S_WAIT: begin
          mem_wdata <= merged;
          mem_wr_en <= 1'b1;
          done      <= 1'b1;
          state     <= S_WRITE;
        end
        S_WRITE: begin
          mem_wr_en <= 1'b0;
          done      <= 1'b0;
          req_ready <= 1'b1;
          state     <= S_IDLE;
        end
        S_ERR: begin
          err       <= 1'b0;
          req_ready <= 1'b1;
          state     <= S_IDLE;
        end
        default: begin
          state     <= S_IDLE;
          req_ready <= 1'b1;
          mem_rd_en <= 1'b0;
          mem_wr_en <= 1'b0;
          done      <= 1'b0;
          err       <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_store_merge_rmw.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_store_merge_rmw : little- and big-endian instances driven in lockstep, |
// | checked per cycle against a transaction-level model.   Revision: 1.0     |
// +--------------------------------------------------------------------------+
module tb_store_merge_rmw;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, req_valid;
  logic [31:0] req_addr, req_data;
  logic [1:0]  req_size;

  logic        ready0, rd0, wr0, done0, err0;
  logic        ready1, rd1, wr1, done1, err1;
  logic [31:0] addr0, wd0, rdata0, addr1, wd1, rdata1;

  store_merge_rmw #(.ADDR_W(32), .BIG_ENDIAN(1'b0)) dut_le (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(ready0),
    .req_addr(req_addr), .req_data(req_data), .req_size(req_size),
    .mem_addr(addr0), .mem_rd_en(rd0), .mem_rdata(rdata0), .mem_wr_en(wr0),
    .mem_wdata(wd0), .done(done0), .err(err0));

  store_merge_rmw #(.ADDR_W(32), .BIG_ENDIAN(1'b1)) dut_be (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(ready1),
    .req_addr(req_addr), .req_data(req_data), .req_size(req_size),
    .mem_addr(addr1), .mem_rd_en(rd1), .mem_rdata(rdata1), .mem_wr_en(wr1),
    .mem_wdata(wd1), .done(done1), .err(err1));

  // Physical memories seen by each instance, and the model's view of them.
  logic [31:0] mem0 [0:1023];
  logic [31:0] mem1 [0:1023];
  logic [31:0] ref0 [0:1023];
  logic [31:0] ref1 [0:1023];

  always @(posedge clk) begin
    if (rd0) rdata0 <= mem0[addr0[11:2]];
    if (wr0) mem0[addr0[11:2]] <= wd0;
    if (rd1) rdata1 <= mem1[addr1[11:2]];
    if (wr1) mem1[addr1[11:2]] <= wd1;
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ctl = {req_ready, mem_rd_en, mem_wr_en, done, err}
  typedef struct {
    logic [4:0]  ctl;
    logic        ca;
    logic [31:0] a;
    logic        cw;
    logic [31:0] w0;
    logic [31:0] w1;
  } exp_t;

  exp_t q[$];
  exp_t cur;

  task automatic push(input logic [4:0] ctl, input logic ca, input logic [31:0] a,
                      input logic cw, input logic [31:0] w0, input logic [31:0] w1);
    exp_t e;
    e.ctl = ctl; e.ca = ca; e.a = a; e.cw = cw; e.w0 = w0; e.w1 = w1;
    q.push_back(e);
  endtask

  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      cur = q.pop_front();
      chk("ctl_le", {27'd0, ready0, rd0, wr0, done0, err0}, {27'd0, cur.ctl});
      chk("ctl_be", {27'd0, ready1, rd1, wr1, done1, err1}, {27'd0, cur.ctl});
      if (cur.ca) begin
        chk("addr_le", addr0, cur.a);
        chk("addr_be", addr1, cur.a);
      end
      if (cur.cw) begin
        chk("wdata_le", wd0, cur.w0);
        chk("wdata_be", wd1, cur.w1);
      end
    end
  end

  function automatic bit illegal_m(input logic [31:0] addr, input logic [1:0] size);
    return (size == 2'd3) || (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'd0);
  endfunction

  function automatic logic [31:0] merge_m(input logic [31:0] old, input logic [31:0] addr,
                                          input logic [31:0] data, input logic [1:0] size,
                                          input bit be);
    int lane;
    logic [31:0] mask, ins;
    if (size == 2'd2) return data;
    if (size == 2'd0) begin
      lane = int'(addr[1:0]);
      if (be) lane = 3 - lane;
      mask = 32'hFF << (8 * lane);
      ins  = (data & 32'hFF) << (8 * lane);
    end else begin
      lane = int'(addr[1]);
      if (be) lane = 1 - lane;
      mask = 32'hFFFF << (16 * lane);
      ins  = (data & 32'hFFFF) << (16 * lane);
    end
    return (old & ~mask) | ins;
  endfunction

  task automatic junk();
    req_valid = 1'($urandom_range(0, 1));
    req_addr  = $urandom;
    req_data  = $urandom;
    req_size  = 2'($urandom_range(0, 3));
  endtask

  task automatic idle();
    @(negedge clk);
    reset = 1'b0; req_valid = 1'b0;
    push(5'b10000, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0);
    @(posedge clk);
  endtask

  task automatic preload(input logic [31:0] wa, input logic [31:0] val);
    @(negedge clk);
    mem0[wa[11:2]] = val; mem1[wa[11:2]] = val;
    ref0[wa[11:2]] = val; ref1[wa[11:2]] = val;
    reset = 1'b0; req_valid = 1'b0;
    push(5'b10000, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0);
    @(posedge clk);
  endtask

  // One request from IDLE back to IDLE; abort asserts reset during WAIT.
  task automatic store(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] size,
                       input bit abort, input bit use_lit,
                       input logic [31:0] lit0, input logic [31:0] lit1);
    logic [31:0] wa, n0, n1;
    bit bad;
    wa  = addr & ~32'd3;
    bad = illegal_m(addr, size);
    n0  = merge_m(ref0[wa[11:2]], addr, data, size, 1'b0);
    n1  = merge_m(ref1[wa[11:2]], addr, data, size, 1'b1);
    if (use_lit) begin
      chk("model_le", n0, lit0);
      chk("model_be", n1, lit1);
      n0 = lit0; n1 = lit1;
    end
    @(negedge clk);
    reset = 1'b0; req_valid = 1'b1;
    req_addr = addr; req_data = data; req_size = size;
    if (bad) begin
      push(5'b00001, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0);
      @(posedge clk); @(negedge clk); junk();
      push(5'b10000, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0);
      @(posedge clk);
    end else if (size == 2'd2) begin
      push(5'b00110, 1'b1, wa, 1'b1, n0, n1);
      @(posedge clk); @(negedge clk); junk();
      push(5'b10000, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0);
      @(posedge clk);
      ref0[wa[11:2]] = n0; ref1[wa[11:2]] = n1;
    end else begin
      push(5'b01000, 1'b1, wa, 1'b0, 32'd0, 32'd0);
      @(posedge clk); @(negedge clk); junk();
      push(5'b00000, 1'b1, wa, 1'b0, 32'd0, 32'd0);
      @(posedge clk);
      if (abort) begin
        @(negedge clk);
        reset = 1'b1; req_valid = 1'b0;
        push(5'b10000, 1'b1, 32'd0, 1'b1, 32'd0, 32'd0);
        @(posedge clk);
        idle();
      end else begin
        @(negedge clk); junk();
        push(5'b00110, 1'b1, wa, 1'b1, n0, n1);
        @(posedge clk); @(negedge clk); junk();
        push(5'b10000, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0);
        @(posedge clk);
        ref0[wa[11:2]] = n0; ref1[wa[11:2]] = n1;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; req_valid = 1'b0;
    req_addr = '0; req_data = '0; req_size = '0;
    for (int i = 0; i < 1024; i++) begin
      mem0[i] = 32'h9E3779B9 * i; mem1[i] = 32'h9E3779B9 * i;
      ref0[i] = 32'h9E3779B9 * i; ref1[i] = 32'h9E3779B9 * i;
    end
    @(posedge clk);
    @(negedge clk);
    push(5'b10000, 1'b1, 32'd0, 1'b1, 32'd0, 32'd0);
    @(posedge clk);
    idle();

    store(32'h100, 32'hDEADBEEF, 2'd2, 1'b0, 1'b1, 32'hDEADBEEF, 32'hDEADBEEF);

    preload(32'h200, 32'h11223344);
    store(32'h202, 32'h123456AB, 2'd0, 1'b0, 1'b1, 32'h11AB3344, 32'h1122AB44);
    preload(32'h200, 32'h11223344);
    store(32'h200, 32'h123456AB, 2'd0, 1'b0, 1'b1, 32'h112233AB, 32'hAB223344);
    preload(32'h200, 32'h11223344);
    store(32'h201, 32'h123456AB, 2'd0, 1'b0, 1'b1, 32'h1122AB44, 32'h11AB3344);
    preload(32'h200, 32'h11223344);
    store(32'h203, 32'h123456AB, 2'd0, 1'b0, 1'b1, 32'hAB223344, 32'h112233AB);

    preload(32'h300, 32'h11223344);
    store(32'h302, 32'hFFFFCAFE, 2'd1, 1'b0, 1'b1, 32'hCAFE3344, 32'h1122CAFE);

    store(32'h001, 32'h12345678, 2'd1, 1'b0, 1'b0, 32'd0, 32'd0);
    store(32'h002, 32'h12345678, 2'd2, 1'b0, 1'b0, 32'd0, 32'd0);
    store(32'h000, 32'h12345678, 2'd3, 1'b0, 1'b0, 32'd0, 32'd0);

    store(32'h041, 32'h000000EE, 2'd0, 1'b1, 1'b0, 32'd0, 32'd0);
    store(32'h040, 32'hA5A55A5A, 2'd2, 1'b0, 1'b0, 32'd0, 32'd0);

    for (int n = 0; n < 200; n++) begin
      logic [31:0] a, d;
      logic [1:0]  s;
      a = 32'($urandom_range(0, 1023));
      d = $urandom;
      s = 2'($urandom_range(0, 3));
      store(a, d, s, 1'b0, 1'b0, 32'd0, 32'd0);
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) idle();
    end

    idle();
    idle();
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
